// File: rtl/ste_seg7_decode.sv
// ste_seg7_decode
//   Snoops a multiplexed, active-low 7-segment bus and rebuilds the four
//   displayed digits as nibbles plus dot bits. Dimming gaps, anode-switch
//   ghosting, multi-anode selects and unknown patterns are filtered out. A
//   digit is committed only after STABLE_SCANS identical samples.
//
//   Ports
//     clk        system clock
//     reset_i    asynchronous reset, active high
//     seg_i      segments {g,f,e,d,c,b,a}, active low
//     an_i       digit anodes, active low
//     dp_i       decimal point, active low
//     x_o        committed digits, digit k = x_o[4k+3:4k]
//     x_dp_o     committed dot per digit (1 = lit)
//     blank_o    committed digit is dark
//     err_o      last sample of the digit was an unknown pattern
//     valid_o    digit committed and not timed out
//     upd_pls_o  one-cycle pulse when any committed field changes
//
//   ste_seg7_digit (same file) holds the per-digit candidate, stability,
//   commit and timeout state; the top holds the synchronizer, the settle
//   counter and the pattern decoder shared by all digits.

module ste_seg7_digit #(
  parameter int STABLE_SCANS = 2,
  parameter int TO_W         = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       smp_i,        // a sample of this digit is taken this edge
  input  logic       smp_ok_i,     // sampled pattern was a known glyph
  input  logic [3:0] smp_nib_i,
  input  logic       smp_dp_i,
  input  logic       smp_blank_i,
  output logic [3:0] x_o,
  output logic       x_dp_o,
  output logic       blank_o,
  output logic       err_o,
  output logic       valid_o,
  output logic       chg_o         // commit this edge alters a committed field
);

  localparam logic [3:0]      SCANS  = 4'(STABLE_SCANS);
  localparam logic [TO_W-1:0] TO_MAX = '1;

  typedef struct packed {
    logic [3:0] nib;
    logic       dp;
    logic       blank;
  } dig_t;

  dig_t            smp;
  dig_t            cand_q, cand_d;
  dig_t            com_q, com_d;
  logic [3:0]      mcnt_q, mcnt_d;
  logic            pend_q, pend_d;   // candidate reached STABLE_SCANS at last sample
  logic            err_q, err_d;
  logic            valid_q, valid_d;
  logic [TO_W-1:0] to_q, to_d;

  assign smp = {smp_nib_i, smp_dp_i, smp_blank_i};

  always_comb begin
    cand_d  = cand_q;
    mcnt_d  = mcnt_q;
    pend_d  = 1'b0;
    err_d   = err_q;
    com_d   = com_q;
    valid_d = valid_q;
    to_d    = (to_q == TO_MAX) ? to_q : to_q + TO_W'(1);

    if (smp_i) begin
      to_d = '0;
      if (smp_ok_i) begin
        err_d = 1'b0;
        if (smp == cand_q) begin
          mcnt_d = (mcnt_q >= SCANS) ? SCANS : mcnt_q + 4'd1;
        end else begin
          cand_d = smp;
          mcnt_d = 4'd1;
        end
        // A saturated candidate re-commits on every matching sample; this is
        // what re-validates a digit that timed out without changing value.
        pend_d = (mcnt_d == SCANS);
      end else begin
        err_d  = 1'b1;
        mcnt_d = 4'd0;
      end
    end

    if (to_d == TO_MAX) valid_d = 1'b0;

    // Commit lands one edge after the sample edge. cand_q is still the value
    // that set pend_q, even if a new sample updates cand on this same edge.
    if (pend_q) begin
      com_d   = cand_q;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q  <= '0;
      mcnt_q  <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      com_q   <= '0;
      valid_q <= 1'b0;
      to_q    <= '0;
    end else begin
      cand_q  <= cand_d;
      mcnt_q  <= mcnt_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      com_q   <= com_d;
      valid_q <= valid_d;
      to_q    <= to_d;
    end
  end

  assign chg_o   = pend_q && (cand_q != com_q);
  assign x_o     = com_q.nib;
  assign x_dp_o  = com_q.dp;
  assign blank_o = com_q.blank;
  assign err_o   = err_q;
  assign valid_o = valid_q;

endmodule

module ste_seg7_decode #(
  parameter int SYNC         = 1,
  parameter int SETTLE_CYC   = 4,
  parameter int STABLE_SCANS = 2,
  parameter int TO_W         = 20
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic [6:0]  seg_i,
  input  logic [3:0]  an_i,
  input  logic        dp_i,
  output logic [15:0] x_o,
  output logic [3:0]  x_dp_o,
  output logic [3:0]  blank_o,
  output logic [3:0]  err_o,
  output logic [3:0]  valid_o,
  output logic        upd_pls_o
);

  localparam int         NUM_DIG = 4;
  localparam logic [7:0] SET_MAX = 8'(SETTLE_CYC);
  localparam logic [7:0] SET_HIT = 8'(SETTLE_CYC - 1);

  // Input vector layout: {an[3:0], seg[6:0], dp}
  logic [11:0] raw_vec, in_vec;
  logic [11:0] prev_q;
  logic [7:0]  run_q, run_d;
  logic        upd_pls_q, upd_pls_d;

  logic [3:0]  an_n;      // active-high anode view
  logic [6:0]  pat;       // active-high segment view
  logic        legal;
  logic        smp;
  logic        dec_ok, dec_blank;
  logic [3:0]  dec_nib;

  logic [NUM_DIG-1:0][3:0] dig_x;
  logic [NUM_DIG-1:0]      dig_dp, dig_blank, dig_err, dig_valid, dig_chg;

  assign raw_vec = {an_i, seg_i, dp_i};

  generate
    if (SYNC != 0) begin : g_sync
      logic [11:0] s1_q, s2_q;
      always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
          s1_q <= '0;
          s2_q <= '0;
        end else begin
          s1_q <= raw_vec;
          s2_q <= s1_q;
        end
      end
      assign in_vec = s2_q;
    end else begin : g_nosync
      assign in_vec = raw_vec;
    end
  endgenerate

  assign an_n = ~in_vec[11:8];
  assign pat  = ~in_vec[7:1];

  // Exactly one anode low; all-high (dimming gap) and multi-low are rejected.
  assign legal = (an_n != 4'd0) && ((an_n & (an_n - 4'd1)) == 4'd0);

  // run_d counts identical cycles minus one; it saturates above the hit
  // value so a long dwell yields exactly one sample.
  always_comb begin
    run_d = 8'd0;
    if (legal && (in_vec == prev_q))
      run_d = (run_q >= SET_MAX) ? SET_MAX : run_q + 8'd1;
  end

  assign smp = legal && (run_d == SET_HIT);

  always_comb begin
    dec_ok    = 1'b1;
    dec_blank = 1'b0;
    dec_nib   = 4'h0;
    case (pat)
      7'h3F: dec_nib = 4'h0;
      7'h06: dec_nib = 4'h1;
      7'h5B: dec_nib = 4'h2;
      7'h4F: dec_nib = 4'h3;
      7'h66: dec_nib = 4'h4;
      7'h6D: dec_nib = 4'h5;
      7'h7D: dec_nib = 4'h6;
      7'h07: dec_nib = 4'h7;
      7'h7F: dec_nib = 4'h8;
      7'h6F: dec_nib = 4'h9;
      7'h77: dec_nib = 4'hA;
      7'h7C: dec_nib = 4'hB;
      7'h39: dec_nib = 4'hC;
      7'h5E: dec_nib = 4'hD;
      7'h79: dec_nib = 4'hE;
      7'h71: dec_nib = 4'hF;
      7'h00: dec_blank = 1'b1;
      default: dec_ok = 1'b0;
    endcase
  end

  generate
    for (genvar k = 0; k < NUM_DIG; k++) begin : g_dig
      ste_seg7_digit #(
        .STABLE_SCANS (STABLE_SCANS),
        .TO_W         (TO_W)
      ) u_dig (
        .clk         (clk),
        .rst         (reset_i),
        .smp_i       (smp && an_n[k]),
        .smp_ok_i    (dec_ok),
        .smp_nib_i   (dec_nib),
        .smp_dp_i    (~in_vec[0]),
        .smp_blank_i (dec_blank),
        .x_o         (dig_x[k]),
        .x_dp_o      (dig_dp[k]),
        .blank_o     (dig_blank[k]),
        .err_o       (dig_err[k]),
        .valid_o     (dig_valid[k]),
        .chg_o       (dig_chg[k])
      );
    end
  endgenerate

  // Registered alongside the commit so the pulse and new values coincide.
  assign upd_pls_d = |dig_chg;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      prev_q    <= '0;
      run_q     <= '0;
      upd_pls_q <= 1'b0;
    end else begin
      prev_q    <= in_vec;
      run_q     <= run_d;
      upd_pls_q <= upd_pls_d;
    end
  end

  assign x_o       = dig_x;
  assign x_dp_o    = dig_dp;
  assign blank_o   = dig_blank;
  assign err_o     = dig_err;
  assign valid_o   = dig_valid;
  assign upd_pls_o = upd_pls_q;

endmodule

// File: tb/tb_ste_seg7_decode.sv
// Directed bench for ste_seg7_decode. Two instances share the same stimulus:
// u0 without synchronizer, u1 with it (commits expected 2 cycles later).
// Both use SETTLE_CYC=4, STABLE_SCANS=2, TO_W=6.

module tb_ste_seg7_decode;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [6:0]  seg_i;
  logic [3:0]  an_i;
  logic        dp_i;

  logic [15:0] x0, x1;
  logic [3:0]  dp0, dp1, bl0, bl1, er0, er1, va0, va1;
  logic        up0, up1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_no = 0;
  int p0_cnt, p1_cnt, p0_last, p1_last;

  always #5 clk = ~clk;

  ste_seg7_decode #(.SYNC(0), .SETTLE_CYC(4), .STABLE_SCANS(2), .TO_W(6)) u0 (
    .clk(clk), .reset_i(reset_i), .seg_i(seg_i), .an_i(an_i), .dp_i(dp_i),
    .x_o(x0), .x_dp_o(dp0), .blank_o(bl0), .err_o(er0), .valid_o(va0),
    .upd_pls_o(up0));

  ste_seg7_decode #(.SYNC(1), .SETTLE_CYC(4), .STABLE_SCANS(2), .TO_W(6)) u1 (
    .clk(clk), .reset_i(reset_i), .seg_i(seg_i), .an_i(an_i), .dp_i(dp_i),
    .x_o(x1), .x_dp_o(dp1), .blank_o(bl1), .err_o(er1), .valid_o(va1),
    .upd_pls_o(up1));

  // Advance n cycles, sampling #1 after each rising edge and logging pulses.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc_no++;
      if (up0) begin p0_cnt++; p0_last = cyc_no; end
      if (up1) begin p1_cnt++; p1_last = cyc_no; end
    end
  endtask

  task automatic clr_p();
    p0_cnt = 0; p1_cnt = 0; p0_last = -1; p1_last = -1;
  endtask

  task automatic set_idle();
    an_i = 4'hF; seg_i = 7'h7F; dp_i = 1'b1;
  endtask

  // pat is active-high segments, dpl = 1 lights the dot
  task automatic set_dig(input int k, input logic [6:0] pat, input logic dpl);
    logic [3:0] a;
    a = 4'b0001 << k;
    an_i = ~a; seg_i = ~pat; dp_i = ~dpl;
  endtask

  task automatic dwell(input int k, input logic [6:0] pat, input logic dpl);
    set_dig(k, pat, dpl); step(8);
    set_idle(); step(4);
  endtask

  task automatic scan();
    dwell(0, 7'h6D, 1'b1);
    dwell(1, 7'h4F, 1'b0);
    dwell(2, 7'h00, 1'b0);
    dwell(3, 7'h7D, 1'b0);
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      seg_i = 7'($urandom); an_i = 4'($urandom); dp_i = 1'($urandom);
      @(posedge clk); #1;
      n_cmp++;
      if ({x0, dp0, bl0, er0, va0, up0} !== 33'd0) begin
        n_bad++; $display("FAIL reset_u0: got %h want 0", {x0, dp0, bl0, er0, va0, up0});
      end
      n_cmp++;
      if ({x1, dp1, bl1, er1, va1, up1} !== 33'd0) begin
        n_bad++; $display("FAIL reset_u1: got %h want 0", {x1, dp1, bl1, er1, va1, up1});
      end
    end
    set_idle();
    reset_i = 1'b0;
    step(4);
  endtask

  task automatic test_single();
    int c;
    clr_p();
    c = cyc_no;
    dwell(0, 7'h66, 1'b0);
    // first sample alone must not commit
    n_cmp++;
    if (p0_cnt !== 0 || va0 !== 4'b0000) begin
      n_bad++; $display("FAIL single_early: pulses %0d valid %b want 0 0000", p0_cnt, va0);
    end
    dwell(0, 7'h66, 1'b0);
    n_cmp++;
    if (x0 !== 16'h0004) begin n_bad++; $display("FAIL single_x: got %h want 0004", x0); end
    n_cmp++;
    if (va0 !== 4'b0001) begin n_bad++; $display("FAIL single_valid: got %b want 0001", va0); end
    n_cmp++;
    if (dp0 !== 4'b0000) begin n_bad++; $display("FAIL single_dp: got %b want 0000", dp0); end
    // second sample edge is cycle c+16
    n_cmp++;
    if (p0_cnt !== 1 || p0_last !== c + 17) begin
      n_bad++; $display("FAIL single_pulse_u0: cnt %0d at %0d want 1 at %0d", p0_cnt, p0_last, c + 17);
    end
    n_cmp++;
    if (p1_cnt !== 1 || p1_last !== c + 19) begin
      n_bad++; $display("FAIL single_pulse_u1: cnt %0d at %0d want 1 at %0d", p1_cnt, p1_last, c + 19);
    end
    n_cmp++;
    if (x1 !== 16'h0004 || va1 !== 4'b0001) begin
      n_bad++; $display("FAIL single_u1: x %h valid %b want 0004 0001", x1, va1);
    end
  endtask

  task automatic test_dice_scan();
    clr_p();
    scan();
    scan();
    n_cmp++;
    if (x0 !== 16'h6035) begin n_bad++; $display("FAIL dice_x: got %h want 6035", x0); end
    n_cmp++;
    if (bl0 !== 4'b0100) begin n_bad++; $display("FAIL dice_blank: got %b want 0100", bl0); end
    n_cmp++;
    if (dp0 !== 4'b0001) begin n_bad++; $display("FAIL dice_dp: got %b want 0001", dp0); end
    n_cmp++;
    if (va0 !== 4'b1111) begin n_bad++; $display("FAIL dice_valid: got %b want 1111", va0); end
    n_cmp++;
    if (p0_cnt !== 4) begin n_bad++; $display("FAIL dice_pulses: got %0d want 4", p0_cnt); end
    n_cmp++;
    if ({x1, bl1, dp1, va1} !== {16'h6035, 4'b0100, 4'b0001, 4'b1111} || p1_cnt !== 4) begin
      n_bad++; $display("FAIL dice_u1: x %h bl %b dp %b va %b pulses %0d", x1, bl1, dp1, va1, p1_cnt);
    end
    clr_p();
    scan();
    n_cmp++;
    if (p0_cnt !== 0 || p1_cnt !== 0) begin
      n_bad++; $display("FAIL dice_repeat_pulse: got %0d/%0d want 0/0", p0_cnt, p1_cnt);
    end
    n_cmp++;
    if (x0 !== 16'h6035 || va0 !== 4'b1111) begin
      n_bad++; $display("FAIL dice_repeat_x: x %h valid %b want 6035 1111", x0, va0);
    end
  endtask

  task automatic test_ghost_illegal();
    clr_p();
    dwell(1, 7'h07, 1'b0);           // candidate 7 with one match
    for (int i = 0; i < 3; i++) begin
      set_dig(1, 7'h07, 1'b0); step(3);
      set_idle(); step(4);
    end
    n_cmp++;
    if (x0 !== 16'h6035 || p0_cnt !== 0 || x1 !== 16'h6035) begin
      n_bad++; $display("FAIL ghost_short: x %h/%h pulses %0d want 6035 0", x0, x1, p0_cnt);
    end
    an_i = 4'b1100; seg_i = ~7'h07; dp_i = 1'b1;
    step(20);
    set_idle(); step(4);
    n_cmp++;
    if (x0 !== 16'h6035 || p0_cnt !== 0 || x1 !== 16'h6035) begin
      n_bad++; $display("FAIL ghost_illegal: x %h/%h pulses %0d want 6035 0", x0, x1, p0_cnt);
    end
    dwell(1, 7'h07, 1'b0);           // second real match commits
    n_cmp++;
    if (x0 !== 16'h6075 || p0_cnt !== 1) begin
      n_bad++; $display("FAIL ghost_commit: x %h pulses %0d want 6075 1", x0, p0_cnt);
    end
  endtask

  task automatic test_error();
    clr_p();
    set_dig(2, 7'h49, 1'b0);
    step(4);
    n_cmp++;
    if (er0 !== 4'b0100) begin n_bad++; $display("FAIL err_set: got %b want 0100", er0); end
    step(4);
    set_idle(); step(4);
    n_cmp++;
    if (er1 !== 4'b0100) begin n_bad++; $display("FAIL err_set_u1: got %b want 0100", er1); end
    n_cmp++;
    if (x0 !== 16'h6075 || bl0 !== 4'b0100 || p0_cnt !== 0) begin
      n_bad++; $display("FAIL err_keep: x %h bl %b pulses %0d want 6075 0100 0", x0, bl0, p0_cnt);
    end
    dwell(2, 7'h3F, 1'b0);
    n_cmp++;
    if (er0 !== 4'b0000 || er1 !== 4'b0000) begin
      n_bad++; $display("FAIL err_clear: got %b/%b want 0000", er0, er1);
    end
    n_cmp++;
    if (bl0 !== 4'b0100 || p0_cnt !== 0) begin
      n_bad++; $display("FAIL err_after_one: bl %b pulses %0d want 0100 0", bl0, p0_cnt);
    end
    dwell(2, 7'h3F, 1'b0);
    n_cmp++;
    if (bl0 !== 4'b0000 || x0 !== 16'h6075 || p0_cnt !== 1) begin
      n_bad++; $display("FAIL err_recommit: bl %b x %h pulses %0d want 0000 6075 1", bl0, x0, p0_cnt);
    end
  endtask

  task automatic test_timeout();
    int e0;
    dwell(1, 7'h77, 1'b0);
    set_dig(1, 7'h77, 1'b0);
    step(4);
    e0 = cyc_no;                     // second sample edge of digit 1
    step(1);
    n_cmp++;
    if (va0[1] !== 1'b1 || x0[7:4] !== 4'hA) begin
      n_bad++; $display("FAIL to_commit: valid %b x %h want 1 A", va0[1], x0[7:4]);
    end
    step(3);
    set_idle();
    step(e0 + 62 - cyc_no);
    n_cmp++;
    if (va0[1] !== 1'b1) begin n_bad++; $display("FAIL to_early: got %b want 1", va0[1]); end
    step(1);
    n_cmp++;
    if (va0[1] !== 1'b0) begin n_bad++; $display("FAIL to_drop: got %b want 0", va0[1]); end
    n_cmp++;
    if (x0 !== 16'h60A5) begin n_bad++; $display("FAIL to_keep: got %h want 60a5", x0); end
    step(1);
    n_cmp++;
    if (va1[1] !== 1'b1) begin n_bad++; $display("FAIL to_early_u1: got %b want 1", va1[1]); end
    step(1);
    n_cmp++;
    if (va1[1] !== 1'b0 || x1 !== 16'h60A5) begin
      n_bad++; $display("FAIL to_drop_u1: valid %b x %h want 0 60a5", va1[1], x1);
    end
  endtask

  task automatic test_async_reset();
    clr_p();
    set_dig(3, 7'h7F, 1'b0); step(8);
    set_idle(); step(2);
    reset_i = 1'b1;
    #2;
    n_cmp++;
    if ({x0, dp0, bl0, er0, va0, up0} !== 33'd0) begin
      n_bad++; $display("FAIL areset_u0: got %h want 0", {x0, dp0, bl0, er0, va0, up0});
    end
    n_cmp++;
    if ({x1, dp1, bl1, er1, va1, up1} !== 33'd0) begin
      n_bad++; $display("FAIL areset_u1: got %h want 0", {x1, dp1, bl1, er1, va1, up1});
    end
    step(2);
    reset_i = 1'b0;
    step(4);
    dwell(3, 7'h7F, 1'b0);
    n_cmp++;
    if (x0 !== 16'h0000 || va0 !== 4'b0000 || p0_cnt !== 0) begin
      n_bad++; $display("FAIL areset_fresh: x %h valid %b pulses %0d want 0000 0000 0", x0, va0, p0_cnt);
    end
    dwell(3, 7'h7F, 1'b0);
    n_cmp++;
    if (x0 !== 16'h8000 || va0 !== 4'b1000 || p0_cnt !== 1) begin
      n_bad++; $display("FAIL areset_commit: x %h valid %b pulses %0d want 8000 1000 1", x0, va0, p0_cnt);
    end
    n_cmp++;
    if (x1 !== 16'h8000 || p1_cnt !== 1 || p1_last - p0_last !== 2) begin
      n_bad++; $display("FAIL areset_sync_lat: x %h pulses %0d lag %0d want 8000 1 2", x1, p1_cnt, p1_last - p0_last);
    end
  endtask

  initial begin
    clr_p();
    set_idle();
    test_reset();
    test_single();
    test_dice_scan();
    test_ghost_illegal();
    test_error();
    test_timeout();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
